// File: rtl/sub_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the counter-width helper.
package sub_serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..w, never less than one.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w + 1 <= 2) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/sub_serial_seq_if.sv
// Operand/result handshake bundle for sub_serial_seq.
//   in_valid/in_ready  : operand handshake carrying x, y, b_in
//   out_valid/out_ready: result handshake carrying diff, b_out
//   busy               : operation in flight (RUN or DONE)
// master = producer/consumer side, slave = the subtractor.
interface sub_serial_seq_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             busy;

    modport master (
        output in_valid, x, y, b_in, out_ready,
        input  in_ready, out_valid, diff, b_out, busy
    );

    modport slave (
        input  in_valid, x, y, b_in, out_ready,
        output in_ready, out_valid, diff, b_out, busy
    );
endinterface

// File: rtl/sub_serial_bit.sv
// One-bit full subtractor cell: d = x - y - b_in (mod 2), b_out = borrow.
//   x, y, b_in : operand bits and incoming borrow
//   d, b_out   : difference bit and outgoing borrow
module sub_serial_bit (
    input  logic x,
    input  logic y,
    input  logic b_in,
    output logic d,
    output logic b_out
);
    assign d     = x ^ y ^ b_in;
    assign b_out = (~x & y) | (~(x ^ y) & b_in);
endmodule

// File: rtl/sub_serial_seq.sv
// Bit-serial subtractor: diff = x - y - b_in, one bit per clock, LSB first,
// through a single sub_serial_bit cell and a borrow flop.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of sub_serial_seq_if (operands in, result out, busy)
// Result appears WIDTH cycles after the accepting edge and is held until taken.
module sub_serial_seq
    import sub_serial_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input logic            clk,
    input logic            rst,
    sub_serial_seq_if.slave bus
);
    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH-1:0] dsh;
    logic [WIDTH-1:0] dsh_nxt;
    logic [CNT_W-1:0] cnt;
    logic             bor;
    logic             cell_d;
    logic             cell_b;

    // The single cell is reused every cycle in place of a ripple chain.
    sub_serial_bit u_bit (
        .x    (xs[0]),
        .y    (ys[0]),
        .b_in (bor),
        .d    (cell_d),
        .b_out(cell_b)
    );

    // Result shifts in from the MSB so the LSB computed first ends at bit 0.
    always_comb begin
        dsh_nxt            = dsh >> 1;
        dsh_nxt[WIDTH-1]   = cell_d;
    end

    assign bus.in_ready = (state == S_IDLE) & ~rst;

    // FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            xs            <= '0;
            ys            <= '0;
            dsh           <= '0;
            cnt           <= '0;
            bor           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.diff      <= '0;
            bus.b_out     <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        xs       <= bus.x;
                        ys       <= bus.y;
                        bor      <= bus.b_in;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    xs  <= xs >> 1;
                    ys  <= ys >> 1;
                    bor <= cell_b;
                    dsh <= dsh_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        bus.diff      <= dsh_nxt;
                        bus.b_out     <= cell_b;
                        bus.out_valid <= 1'b1;
                        state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
